// File: rtl/decode_stage.sv
// ID stage: buffers a fetched instruction, decodes its immediate format and
// registers the bundle for execute. Optional DECODE_ILLEGAL_EN flags bad opcodes.
module decode_stage #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_inst,
   input  logic [XLEN-1:0] if_pc,
   input  logic            flush,
   output logic [2:0]      immsel,
   output logic [24:0]     inst_31_7,
   input  logic [31:0]     imm_in,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [31:0]     ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_immsel,
   output logic            ex_illegal
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic            id_valid;
   logic [31:0]     id_inst;
   logic [XLEN-1:0] id_pc;
   logic            ex_free;
   logic            id_adv;
   logic            fetch;
   logic            known_op;
   logic            illegal;

   assign ex_free   = !ex_valid | ex_ready;
   assign id_adv    = id_valid & ex_free;
   assign if_ready  = !id_valid | ex_free;
   assign fetch     = if_valid & if_ready;
   assign inst_31_7 = id_inst[31:7];

   always_comb begin
      immsel   = 3'd0;
      known_op = 1'b1;
      case (id_inst[6:0])
         7'b0110011: immsel = 3'd0;
         7'b0010011,
         7'b0000011,
         7'b1100111: immsel = 3'd1;
         7'b0100011: immsel = 3'd2;
         7'b1100011: immsel = 3'd3;
         7'b0110111,
         7'b0010111: immsel = 3'd4;
         7'b1101111: immsel = 3'd5;
         7'b1110011: immsel = 3'd6;
         default: begin
            immsel   = 3'd0;
            known_op = 1'b0;
         end
      endcase
   end

`ifdef DECODE_ILLEGAL_EN
   assign illegal = !known_op | (id_inst[1:0] != 2'b11);
`else
   assign illegal = 1'b0;
   logic unused_known;
   assign unused_known = known_op;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid <= 1'b0;
         id_inst  <= NOP;
         id_pc    <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (fetch) begin
         id_valid <= 1'b1;
         id_inst  <= if_inst;
         id_pc    <= if_pc;
      end else if (id_adv) begin
         id_valid <= 1'b0;
      end
   end

   // EX fields only move on id_adv, so they hold while execute stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_pc       <= RESET_PC_TAG;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct3   <= '0;
         ex_funct7b5 <= 1'b0;
         ex_opcode   <= '0;
         ex_immsel   <= '0;
         ex_illegal  <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (id_adv) begin
         ex_valid    <= 1'b1;
         ex_pc       <= id_pc;
         ex_imm      <= imm_in;
         ex_rs1      <= id_inst[19:15];
         ex_rs2      <= id_inst[24:20];
         ex_rd       <= illegal ? 5'd0 : id_inst[11:7];
         ex_funct3   <= id_inst[14:12];
         ex_funct7b5 <= id_inst[30];
         ex_opcode   <= id_inst[6:0];
         ex_immsel   <= illegal ? 3'd0 : immsel;
         ex_illegal  <= illegal;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a behavioural immediate generator.
module tb_decode_stage;

   localparam logic [31:0] TAG = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        flush;
   logic [2:0]  immsel;
   logic [24:0] inst_31_7;
   logic [31:0] imm_in;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_immsel;
   logic        ex_illegal;

   int checks = 0;
   int failures = 0;

   decode_stage #(.XLEN(32), .RESET_PC_TAG(TAG)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_inst(if_inst), .if_pc(if_pc),
      .flush(flush),
      .immsel(immsel), .inst_31_7(inst_31_7), .imm_in(imm_in),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
      .ex_opcode(ex_opcode), .ex_immsel(ex_immsel),
      .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   // external immediate generator
   logic [31:0] iw;
   assign iw = {inst_31_7, 7'b0};
   always_comb begin
      imm_in = 32'h0;
      case (immsel)
         3'd1: imm_in = {{20{iw[31]}}, iw[31:20]};
         3'd2: imm_in = {{20{iw[31]}}, iw[31:25], iw[11:7]};
         3'd3: imm_in = {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
         3'd4: imm_in = {iw[31:12], 12'h0};
         3'd5: imm_in = {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
         3'd6: imm_in = {27'h0, iw[19:15]};
         default: imm_in = 32'h0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
      if_valid = 1'b1;
      if_inst  = inst;
      if_pc    = pc;
   endtask

   initial begin
      rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0;
      flush = 1'b0; ex_ready = 1'b1;
      #2;
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_ex_pc", ex_pc, TAG);
      check("rst_if_ready", 32'(if_ready), 32'd1);
      check("rst_nop_immsel", 32'(immsel), 32'd1);
      check("rst_inst_31_7", 32'(inst_31_7), 32'd0);
      step();
      step();
      rst = 1'b0;

      // addi x1,x0,5
      offer(32'h0050_0093, 32'h100);
      step();
      if_valid = 1'b0;
      check("lat_not_yet", 32'(ex_valid), 32'd0);
      step();
      check("addi_valid", 32'(ex_valid), 32'd1);
      check("addi_immsel", 32'(ex_immsel), 32'd1);
      check("addi_imm", ex_imm, 32'h5);
      check("addi_rd", 32'(ex_rd), 32'd1);
      check("addi_rs1", 32'(ex_rs1), 32'd0);
      check("addi_pc", ex_pc, 32'h100);
      check("addi_illegal", 32'(ex_illegal), 32'd0);

      // back-to-back sw, beq, lui
      offer(32'h0020_A423, 32'h104);
      step();
      offer(32'hFE00_0EE3, 32'h108);
      step();
      check("sw_immsel", 32'(ex_immsel), 32'd2);
      check("sw_imm", ex_imm, 32'h8);
      check("sw_rs1", 32'(ex_rs1), 32'd1);
      check("sw_rs2", 32'(ex_rs2), 32'd2);
      check("sw_funct3", 32'(ex_funct3), 32'd2);
      check("sw_opcode", 32'(ex_opcode), 32'h23);
      offer(32'h1234_52B7, 32'h10C);
      step();
      if_valid = 1'b0;
      check("beq_immsel", 32'(ex_immsel), 32'd3);
      check("beq_imm", ex_imm, 32'hFFFF_FFFC);
      check("beq_f7b5", 32'(ex_funct7b5), 32'd1);
      check("beq_pc", ex_pc, 32'h108);
      step();
      check("lui_immsel", 32'(ex_immsel), 32'd4);
      check("lui_imm", ex_imm, 32'h1234_5000);
      check("lui_rd", 32'(ex_rd), 32'd5);
      step();
      check("drain_valid", 32'(ex_valid), 32'd0);

      // stall: three offered, two held
      ex_ready = 1'b0;
      offer(32'h0010_0113, 32'h200);
      step();
      check("stall_rdy1", 32'(if_ready), 32'd1);
      offer(32'h0020_0193, 32'h204);
      step();
      check("stall_full", 32'(if_ready), 32'd0);
      check("stall_ex_rd", 32'(ex_rd), 32'd2);
      offer(32'h0030_0213, 32'h208);
      step();
      check("stall_hold_rd", 32'(ex_rd), 32'd2);
      check("stall_hold_imm", ex_imm, 32'h1);
      check("stall_hold_v", 32'(ex_valid), 32'd1);
      check("stall_still", 32'(if_ready), 32'd0);
      ex_ready = 1'b1;
      step();
      if_valid = 1'b0;
      check("rel_i2_rd", 32'(ex_rd), 32'd3);
      check("rel_i2_pc", ex_pc, 32'h204);
      step();
      check("rel_i3_rd", 32'(ex_rd), 32'd4);
      check("rel_i3_v", 32'(ex_valid), 32'd1);
      step();
      check("rel_empty", 32'(ex_valid), 32'd0);

      // flush with both registers full and a fetch handshake
      ex_ready = 1'b0;
      offer(32'h0050_0293, 32'h300);
      step();
      offer(32'h0060_0313, 32'h304);
      step();
      check("fl_full", 32'(if_ready), 32'd0);
      ex_ready = 1'b1;
      offer(32'h0070_0393, 32'h308);
      flush = 1'b1;
      step();
      flush = 1'b0;
      if_valid = 1'b0;
      check("fl_ex_valid", 32'(ex_valid), 32'd0);
      check("fl_if_ready", 32'(if_ready), 32'd1);
      step();
      check("fl_gone1", 32'(ex_valid), 32'd0);
      step();
      check("fl_gone2", 32'(ex_valid), 32'd0);

      // async reset mid-stream
      offer(32'h0080_0413, 32'h400);
      step();
      offer(32'h00A0_0513, 32'h404);
      step();
      check("pre_rst_v", 32'(ex_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(ex_valid), 32'd0);
      check("arst_pc", ex_pc, TAG);
      if_valid = 1'b0;
      step();
      rst = 1'b0;
      offer(32'h0090_0493, 32'h500);
      step();
      if_valid = 1'b0;
      step();
      check("post_rst_v", 32'(ex_valid), 32'd1);
      check("post_rst_rd", 32'(ex_rd), 32'd9);
      check("post_rst_pc", ex_pc, 32'h500);
      step();
      check("post_rst_once", 32'(ex_valid), 32'd0);

      // unrecognised opcodes
      offer(32'h0000_007F, 32'h600);
      step();
      offer(32'h0000_057F, 32'h604);
      step();
      if_valid = 1'b0;
`ifdef DECODE_ILLEGAL_EN
      check("ill_flag", 32'(ex_illegal), 32'd1);
`else
      check("ill_flag", 32'(ex_illegal), 32'd0);
`endif
      check("ill_immsel", 32'(ex_immsel), 32'd0);
      check("ill_rd", 32'(ex_rd), 32'd0);
      step();
`ifdef DECODE_ILLEGAL_EN
      check("ill2_flag", 32'(ex_illegal), 32'd1);
      check("ill2_rd", 32'(ex_rd), 32'd0);
`else
      check("ill2_flag", 32'(ex_illegal), 32'd0);
      check("ill2_rd", 32'(ex_rd), 32'd10);
`endif
      check("ill2_immsel", 32'(ex_immsel), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID pipeline stage of the RISC-V core, between instruction fetch and execute.
- Buffers the fetched instruction and decodes its opcode into `immsel` and control fields.
- Drives the immediate generator combinationally and captures its 32-bit result.
- Registers the decoded bundle into an ID/EX register with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC_TAG, 32'h0000_0000, value loaded into `ex_pc` on reset.

Ports:
- clk  input  1  core clock; all state is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- if_valid  input  1  fetch presents an instruction.
- if_ready  output  1  stage can accept an instruction this cycle.
- if_inst  input  32  fetched instruction.
- if_pc  input  XLEN  PC of `if_inst`.
- flush  input  1  kill all in-flight instructions (branch/jump redirect).
- immsel  output  3  to immgen: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR.
- inst_31_7  output  25  to immgen: held instruction bits [31:7].
- imm_in  input  32  from immgen; combinational result for the current `immsel`/`inst_31_7`.
- ex_valid  output  1  ID/EX bundle valid.
- ex_ready  input  1  execute consumes the bundle.
- ex_pc  output  XLEN  registered PC.
- ex_imm  output  32  registered immediate.
- ex_rs1, ex_rs2, ex_rd  output  5 each  register indices (inst[19:15], [24:20], [11:7]).
- ex_funct3  output  3  inst[14:12].
- ex_funct7b5  output  1  inst[30].
- ex_opcode  output  7  inst[6:0].
- ex_immsel  output  3  registered immsel.
- ex_illegal  output  1  unrecognised opcode (see Optional Feature).

Behaviour:
- State:
  - ID register: `id_valid`, `id_inst`, `id_pc`.
  - EX register: `ex_valid` plus all `ex_*` fields.
- Reset (async, `rst`=1):
  - `id_valid`=0, `ex_valid`=0, `id_inst`=32'h0000_0013 (NOP), `id_pc`=0.
  - All `ex_*` fields=0 except `ex_pc`=RESET_PC_TAG.
  - Outputs valid immediately on `rst` assertion, not at the next edge.
- Decode, combinational from `id_inst[6:0]`:
  - 0110011 → 0
  - 0010011, 0000011, 1100111 → 1
  - 0100011 → 2
  - 1100011 → 3
  - 0110111, 0010111 → 4
  - 1101111 → 5
  - 1110011 → 6
  - all other opcodes → 0
- `inst_31_7` = `id_inst[31:7]` at all times, including when `id_valid`=0.
- Handshake:
  - `ex_free` = !`ex_valid` | `ex_ready`.
  - `id_adv` = `id_valid` & `ex_free`.
  - `if_ready` = !`id_valid` | `ex_free`; combinational, no dependency on `if_valid`.
  - `if_valid` & `if_ready` at an edge loads `id_inst`/`id_pc` and sets `id_valid`=1.
  - `id_adv` at an edge loads the EX register from the ID register and `imm_in`, and sets `ex_valid`=1.
  - `ex_ready` & `ex_valid` with no `id_adv`: `ex_valid`→0.
  - `id_adv` without a new fetch: `id_valid`→0.
  - While `ex_ready`=1 and `if_valid`=1: throughput is 1 instruction/cycle.
- Latency: instruction accepted at edge N appears on `ex_*` after edge N+1, provided execute was free.
- Stall: with `ex_ready`=0 the stage holds up to 2 instructions (ID + EX). It then drops `if_ready`; no loss, no duplication.
- While `ex_valid`=1 and `ex_ready`=0: all `ex_*` fields hold stable.
- Flush, synchronous, highest priority:
  - At the edge: `id_valid`=0 and `ex_valid`=0.
  - The fetch handshake of that same cycle is discarded.
  - Data registers may keep stale values.
- `rst` mid-transfer overrides everything; the first acceptable fetch is at the first edge after deassertion.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined:
  - Opcodes outside the decode list, or `inst[1:0]`≠2'b11, set `ex_illegal`=1 in the bundle.
  - Their `ex_immsel` is 0 and `ex_rd` is forced to 0.
- Undefined: `ex_illegal` is tied to 0 and no `rd` forcing occurs.

Test Plan:
- Reset, then `if_valid`=1 with 32'h00500093 (addi x1,x0,5) and `ex_ready`=1 → one cycle later:
  - `ex_valid`=1, `ex_immsel`=1, `ex_imm`=32'h5, `ex_rd`=1, `ex_rs1`=0.
- Back-to-back 32'h0020A423 (sw), 32'hFE000EE3 (beq -4), 32'h123452B7 (lui x5) →
  - immsel 2/3/4 in consecutive cycles.
  - imm 32'h8 / 32'hFFFFFFFC / 32'h12345000.
- `ex_ready`=0 while 3 instructions are offered →
  - `if_ready`=0 after 2 are accepted.
  - On `ex_ready`=1 all 3 emerge in order, none lost.
- `flush` in the same cycle as a fetch handshake, with both registers full → next cycle:
  - `ex_valid`=0, `if_ready`=1.
  - The flushed-cycle instruction never appears.
- `rst` asserted mid-stream →
  - `ex_valid`=0 and `ex_pc`=RESET_PC_TAG before the next clock edge.
  - Normal operation resumes after deassertion.
- With DECODE_ILLEGAL_EN, input 32'h0000007F → `ex_illegal`=1, `ex_rd`=0, `ex_immsel`=0.
- Without DECODE_ILLEGAL_EN, same input → `ex_illegal`=0.
